// File: rtl/moore_run_detector.sv
// Moore run detector: y_out is high while the last RUN_LEN enabled samples equal pol.
// State index k counts consecutive matches; a saturating counter tallies detections.
module moore_run_detector #(
   parameter int RUN_LEN = 3,
   parameter int CNT_W   = 8,
   parameter int SW      = $clog2(RUN_LEN + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             x_in,
   input  logic             en,
   input  logic             pol,
   input  logic             overlap,
   input  logic             clr_cnt,
   output logic             y_out,
   output logic [SW-1:0]    state,
   output logic [CNT_W-1:0] det_cnt,
   output logic             cnt_sat
);

   localparam logic [SW-1:0] S_IDLE = '0;
   localparam logic [SW-1:0] S_ONE  = SW'(1);
   localparam logic [SW-1:0] S_FULL = SW'(RUN_LEN);

   logic [SW-1:0] state_q;
   logic [SW-1:0] state_d;
   logic          detect;

   always_comb begin
      state_d = state_q;
      if (en) begin
         if (x_in != pol)
            state_d = S_IDLE;
         else if (state_q != S_FULL)
            state_d = state_q + S_ONE;
         else if (overlap)
            state_d = S_FULL;
         else
            state_d = S_ONE;   // equals S_FULL when RUN_LEN is 1
      end
   end

   assign detect = en && (state_d == S_FULL);

   always_ff @(posedge clk) begin
      if (rst)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (rst || clr_cnt)
         det_cnt <= '0;
      else if (detect && (det_cnt != '1))
         det_cnt <= det_cnt + CNT_W'(1);
   end

   assign state   = state_q;
   assign y_out   = (state_q == S_FULL);
   assign cnt_sat = (det_cnt == '1);

endmodule

// File: tb/tb_moore_run_detector.sv
// Directed-vector bench for moore_run_detector with RUN_LEN=3, CNT_W=4.
module tb_moore_run_detector;

   localparam int RUN_LEN = 3;
   localparam int CNT_W   = 4;
   localparam int SW      = $clog2(RUN_LEN + 1);

   logic             clk = 1'b0;
   logic             rst;
   logic             x_in;
   logic             en;
   logic             pol;
   logic             overlap;
   logic             clr_cnt;
   logic             y_out;
   logic [SW-1:0]    state;
   logic [CNT_W-1:0] det_cnt;
   logic             cnt_sat;

   int checks   = 0;
   int failures = 0;

   moore_run_detector #(.RUN_LEN(RUN_LEN), .CNT_W(CNT_W)) dut (
      .clk     (clk),
      .rst     (rst),
      .x_in    (x_in),
      .en      (en),
      .pol     (pol),
      .overlap (overlap),
      .clr_cnt (clr_cnt),
      .y_out   (y_out),
      .state   (state),
      .det_cnt (det_cnt),
      .cnt_sat (cnt_sat)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input logic x, input logic e, input logic c);
      x_in    = x;
      en      = e;
      clr_cnt = c;
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input int st, input int y);
      check({tag, "_state"}, int'(state), st);
      check({tag, "_y"}, int'(y_out), y);
   endtask

   initial begin
      int exp_state [6];
      int exp_y     [6];
      int exp_cnt;

      rst = 1'b1; x_in = 1'b0; en = 1'b1; pol = 1'b0; overlap = 1'b1; clr_cnt = 1'b0;

      // reset with toggling data
      step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      check_out("reset", 0, 0);
      check("reset_cnt", int'(det_cnt), 0);
      check("reset_sat", int'(cnt_sat), 0);
      rst = 1'b0;

      // overlap, zero detect: 1,0,0,0,0,1
      exp_state = '{0, 1, 2, 3, 3, 0};
      exp_y     = '{0, 0, 0, 1, 1, 0};
      begin
         logic [5:0] xs;
         xs = 6'b100001;   // bit 5 first
         for (int i = 0; i < 6; i++) begin
            step(xs[5-i], 1'b1, 1'b0);
            check_out($sformatf("ovl_e%0d", i + 1), exp_state[i], exp_y[i]);
         end
      end
      check("ovl_cnt", int'(det_cnt), 2);

      // non-overlap: six zeros from S0, counter cleared while idle
      step(1'b0, 1'b0, 1'b1);
      overlap = 1'b0;
      exp_state = '{1, 2, 3, 1, 2, 3};
      exp_y     = '{0, 0, 1, 0, 0, 1};
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 1'b1, 1'b0);
         check_out($sformatf("novl_e%0d", i + 1), exp_state[i], exp_y[i]);
      end
      check("novl_cnt", int'(det_cnt), 2);

      // saturation: start from S0 with cleared counter, then 20 ones
      pol = 1'b1;
      overlap = 1'b1;
      step(1'b0, 1'b1, 1'b1);
      check("sat_pre_state", int'(state), 0);
      check("sat_pre_cnt", int'(det_cnt), 0);
      exp_cnt = 0;
      for (int i = 1; i <= 20; i++) begin
         step(1'b1, 1'b1, 1'b0);
         if (i >= 3 && exp_cnt < 15) exp_cnt++;
         check($sformatf("sat_cnt_e%0d", i), int'(det_cnt), exp_cnt);
         check($sformatf("sat_flag_e%0d", i), int'(cnt_sat), (i >= 17) ? 1 : 0);
      end
      // clear wins over a simultaneous detection
      step(1'b1, 1'b1, 1'b1);
      check("clr_cnt", int'(det_cnt), 0);
      check("clr_sat", int'(cnt_sat), 0);
      check_out("clr", 3, 1);

      // enable gating
      pol = 1'b0;
      step(1'b1, 1'b1, 1'b1);
      check_out("gate_idle", 0, 0);
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      check_out("gate_run", 2, 0);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 1'b0);
         check_out($sformatf("gate_hold%0d", i), 2, 0);
      end
      step(1'b0, 1'b1, 1'b0);
      check_out("gate_done", 3, 1);
      check("gate_cnt", int'(det_cnt), 1);

      // reset mid-run
      step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      check_out("mid_pre", 2, 0);
      rst = 1'b1;
      step(1'b0, 1'b1, 1'b0);
      rst = 1'b0;
      check_out("mid_rst", 0, 0);
      check("mid_rst_cnt", int'(det_cnt), 0);
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      check_out("mid_two", 2, 0);
      step(1'b0, 1'b1, 1'b0);
      check_out("mid_three", 3, 1);
      check("mid_cnt", int'(det_cnt), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/moore_run_detector.md
# moore_run_detector

Parametrised Moore-machine run detector, the generalised successor to the two-state serial zero detector in the sequential-logic examples. It samples a serial bit stream and asserts a registered output while the last `RUN_LEN` enabled samples all equal a selectable polarity. It adds overlap/non-overlap modes, sample gating, an exposed state index for structural cross-checking, and a saturating detection counter. It is used standalone in the chapter examples and as a reference model against hand-built structural variants.

## Interface

Parameters
- `RUN_LEN`, 3, number of consecutive matching bits required; legal range is 1 to 255.
- `CNT_W`, 8, width of the detection counter; must be at least 1.
- `SW`, `$clog2(RUN_LEN+1)`, state index width. Derived; do not override.

Ports
- `clk`  in  1  single clock; all logic updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `x_in`  in  1  serial data bit.
- `en`  in  1  sample enable. When 0, the sample is ignored.
- `pol`  in  1  target bit value: 0 detects zeros, 1 detects ones.
- `overlap`  in  1  run mode: 1 = overlapping detections, 0 = non-overlapping.
- `clr_cnt`  in  1  synchronous clear of `det_cnt` and `cnt_sat`.
- `y_out`  out  1  Moore output, 1 exactly when `state == RUN_LEN`.
- `state`  out  SW  current state index k (k consecutive matches seen).
- `det_cnt`  out  CNT_W  saturating count of detections.
- `cnt_sat`  out  1  1 once `det_cnt` has reached its all-ones value.

## Operation

- States are S0 through S_RUN_LEN. `state` outputs the index directly.
- The next-state rule applies only on edges where `en = 1`. Let m = (`x_in == pol`).
  - m = 0: go to S0 from any state.
  - m = 1 and k < RUN_LEN: go to S(k+1).
  - m = 1, k = RUN_LEN, `overlap = 1`: stay in S_RUN_LEN. Each further matching bit counts as a new detection.
  - m = 1, k = RUN_LEN, `overlap = 0`: go to S1. When RUN_LEN = 1, this target is S_RUN_LEN itself.
- When `en = 0`, `state` holds its value.
- `y_out` is decoded from the state register only. It is never combinational from `x_in`.
- Detection event: an edge with `en = 1` whose next state is S_RUN_LEN.
- `det_cnt` rules:
  - Increments by 1 on each detection event.
  - Saturates at 2^CNT_W − 1 and never wraps.
  - `cnt_sat` is 1 whenever `det_cnt` is all ones.
- Counter priority, highest first: `rst`, then `clr_cnt`, then increment. If `clr_cnt` and a detection occur on the same edge, `det_cnt` becomes 0.
- `clr_cnt` acts regardless of `en`. It does not affect `state`.
- A `pol` or `overlap` change takes effect on the next sampled bit. It does not reset `state`. The run count continues, judged against the new `pol`.
- Reset values: `state` = 0, `y_out` = 0, `det_cnt` = 0, `cnt_sat` = 0.
- `rst` overrides `en` and `clr_cnt`. Reset mid-run discards partial progress.

## Timing

- Inputs are sampled at the rising edge of `clk`.
- `y_out` rises immediately after the edge that samples the RUN_LEN-th consecutive matching bit. Latency is 0 cycles from that sampling edge and 1 cycle from input presentation.
- `y_out` falls immediately after the edge that samples a non-matching bit. In non-overlap mode with RUN_LEN > 1, it also falls after the edge that samples the next matching bit.
- `det_cnt` and `cnt_sat` update on the same edge as the detection event.
- There are no combinational paths from inputs to outputs.

## Test plan

All scenarios use RUN_LEN = 3 and CNT_W = 4 unless noted.

- **Reset:** `rst` = 1 for 2 edges while `x_in` toggles and `en` = 1 → `state` = 0, `y_out` = 0, `det_cnt` = 0, `cnt_sat` = 0.
- **Overlap, zero detect:** `pol` = 0, `overlap` = 1, `x_in` = 1,0,0,0,0,1 → `state` = 0,1,2,3,3,0. `y_out` is high after edges 4 and 5. `det_cnt` = 2.
- **Non-overlap:** `overlap` = 0, `x_in` = 0 for six edges → `state` = 1,2,3,1,2,3. `y_out` is high after edges 3 and 6. `det_cnt` = 2.
- **Saturation and clear:** `pol` = 1, `overlap` = 1, `x_in` = 1 for 20 edges.
  - `det_cnt` reaches 15 on edge 17 and holds; `cnt_sat` = 1.
  - `clr_cnt` = 1 with `x_in` still 1 → `det_cnt` = 0, `cnt_sat` = 0. `state` stays 3.
- **Enable gating:** `pol` = 0, `x_in` = 0,0 with `en` = 1, then 3 edges with `en` = 0 and `x_in` = 1, then `x_in` = 0 with `en` = 1 → `state` holds 2 through the gap, then goes to 3. `y_out` rises; `det_cnt` = 1.
- **Reset mid-run:** reach `state` = 2, assert `rst` for 1 edge → `state` = 0. Two more zeros give `state` = 2 and `y_out` = 0; a third zero gives `y_out` = 1.
